// File: rtl/inagu_ctrl.sv
// -----------------------------------------------------------------------------
// inagu_ctrl
//
// Job sequencer for the input/weight address generator of the MVU datapath.
// A single job is accepted over a start/ready handshake. The sequencer then
// clears the address generator, steps it cfg_len times while honouring memory
// back-pressure, and waits LATENCY cycles for the downstream pipeline to drain.
// Accumulator-done events are counted while the job is stepping or draining.
// Normal completion and abort are each reported with a single-cycle pulse.
//
// Parameters
//   BCNT     width of the job step count (max job = 2^BCNT-1 steps)
//   BACC     width of the saturating accumulation-done counter
//   LATENCY  drain cycles after the last step, 0..15
//
// Ports
//   clk         clock
//   rst         asynchronous active-high reset
//   start       job request, accepted when start & ready
//   cfg_len     number of enabled steps, sampled on accept
//   stall       back-pressure, suppresses stepping while high
//   abort       terminates the active job (CLR, RUN or DRAIN)
//   shacc_done  accumulation-done pulse from the address generator
//   ready       idle, a job can be accepted
//   busy        job in progress (any state other than IDLE)
//   agu_clr     clear to the address generator
//   agu_en      step enable to the address generator (combinational in RUN)
//   done        one-cycle pulse, job completed normally
//   aborted     one-cycle pulse, job terminated by abort
//   acc_count   shacc_done events counted in the current/last job
// -----------------------------------------------------------------------------
module inagu_ctrl #(
    parameter int BCNT    = 24,
    parameter int BACC    = 16,
    parameter int LATENCY = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BCNT-1:0] cfg_len,
    input  logic            stall,
    input  logic            abort,
    input  logic            shacc_done,
    output logic            ready,
    output logic            busy,
    output logic            agu_clr,
    output logic            agu_en,
    output logic            done,
    output logic            aborted,
    output logic [BACC-1:0] acc_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    localparam logic [BCNT-1:0] REM_ZERO  = {BCNT{1'b0}};
    localparam logic [BCNT-1:0] REM_ONE   = {{(BCNT-1){1'b0}}, 1'b1};
    localparam logic [3:0]      DCNT_INIT = 4'(LATENCY);
    localparam logic [3:0]      DCNT_ZERO = 4'd0;
    localparam logic [3:0]      DCNT_ONE  = 4'd1;
    localparam logic [BACC-1:0] ACC_ZERO  = {BACC{1'b0}};
    localparam logic [BACC-1:0] ACC_ONE   = {{(BACC-1){1'b0}}, 1'b1};
    localparam logic [BACC-1:0] ACC_MAX   = {BACC{1'b1}};

    state_t          state_q,   state_d;
    logic [BCNT-1:0] rem_q,     rem_d;
    logic [3:0]      dcnt_q,    dcnt_d;
    logic [BACC-1:0] acc_q,     acc_d;
    logic            ready_q,   ready_d;
    logic            busy_q,    busy_d;
    logic            clr_q,     clr_d;
    logic            done_q,    done_d;
    logic            aborted_q, aborted_d;

    logic            accept_s;
    logic            agu_en_s;
    logic            count_win_s;

    // Handshake qualifier, step enable and the window in which accumulator
    // events are counted. agu_en must react to stall/abort in the same cycle,
    // so it is decoded combinationally from the registered state.
    always_comb begin
        accept_s    = start & ready_q;
        agu_en_s    = (state_q == S_RUN) & ~stall & ~abort;
        count_win_s = (state_q == S_RUN) | (state_q == S_DRAIN);
    end

    // Next-state and step/drain counter logic. Abort is tested before the
    // step so that an abort coinciding with the final step leaves rem intact.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    rem_d = cfg_len;
                    if (cfg_len == REM_ZERO) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (agu_en_s) begin
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        if (DCNT_INIT == DCNT_ZERO) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DRAIN;
                            dcnt_d  = DCNT_INIT;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else begin
                    // A zero count here cannot happen in normal operation;
                    // treat it like the last drain cycle so the job never hangs.
                    if ((dcnt_q == DCNT_ONE) || (dcnt_q == DCNT_ZERO)) begin
                        dcnt_d  = DCNT_ZERO;
                        state_d = S_DONE;
                    end else begin
                        dcnt_d  = dcnt_q - DCNT_ONE;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Accumulator-done counter: cleared on accept, saturating count while the
    // generator is stepping or draining, held everywhere else.
    always_comb begin
        acc_d = acc_q;
        if (accept_s) begin
            acc_d = ACC_ZERO;
        end else if (count_win_s && shacc_done) begin
            if (acc_q == ACC_MAX) begin
                acc_d = ACC_MAX;
            end else begin
                acc_d = acc_q + ACC_ONE;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Output decode from the next state so every status output is a flop.
    always_comb begin
        ready_d   = (state_d == S_IDLE);
        busy_d    = (state_d != S_IDLE);
        clr_d     = (state_d == S_CLR) || (state_d == S_ABORT);
        done_d    = (state_d == S_DONE);
        aborted_d = (state_d == S_ABORT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= REM_ZERO;
            dcnt_q    <= DCNT_ZERO;
            acc_q     <= ACC_ZERO;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            dcnt_q    <= dcnt_d;
            acc_q     <= acc_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            clr_q     <= clr_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign agu_clr   = clr_q;
    assign agu_en    = agu_en_s;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign acc_count = acc_q;

endmodule

// File: doc/inagu_ctrl.md
# inagu_ctrl

Job sequencer for the input/weight address generator of the MVU datapath. It accepts one job at a time over a start/ready handshake and drives the generator's `clr` and `en` lines. It steps the generator a programmed number of times, honouring memory back-pressure, then drains the downstream pipeline. It counts accumulator-done events during the job and reports completion or abort with single-cycle pulses.

## Interface
- `BCNT`, 24: width of job step count.
- `BACC`, 16: width of accumulation-done counter.
- `LATENCY`, 3: drain cycles after the last step (range 0..15).

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request; accepted when `start & ready`.
- `cfg_len`  in  BCNT  number of enabled steps for the job; sampled on accept.
- `stall`  in  1  back-pressure; suppresses stepping while high.
- `abort`  in  1  terminate the active job.
- `shacc_done`  in  1  accumulation-done pulse from the address generator.
- `ready`  out  1  idle, can accept a job.
- `busy`  out  1  job in progress (any state except IDLE).
- `agu_clr`  out  1  clear to the address generator.
- `agu_en`  out  1  step enable to the address generator.
- `done`  out  1  one-cycle pulse: job completed normally.
- `aborted`  out  1  one-cycle pulse: job terminated by abort.
- `acc_count`  out  BACC  `shacc_done` events counted in current/last job.

## Operation
- States: IDLE, CLR, RUN, DRAIN, DONE, ABORT. State and counters are registered.
- IDLE:
  - `ready`=1.
  - On accept, latch `rem`=`cfg_len` and clear `acc_count`.
  - If `cfg_len`==0, go to DONE; otherwise go to CLR.
- CLR: `agu_clr`=1 for exactly one cycle, then RUN.
- RUN:
  - `agu_en` = ~`stall` & ~`abort` (combinational).
  - Each cycle with `agu_en`=1 decrements `rem`.
  - When `agu_en`=1 and `rem`==1: go to DRAIN, loading `dcnt`=`LATENCY`. If `LATENCY`==0, go directly to DONE.
- DRAIN:
  - `agu_en`=0 and `stall` is ignored.
  - Decrement `dcnt` each cycle; when `dcnt`==1, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- ABORT: `agu_clr`=1 and `aborted`=1 for one cycle, then IDLE.
- `abort` in CLR, RUN or DRAIN: next state is ABORT. `abort` in IDLE or DONE is ignored.
- `acc_count`:
  - Increments on `shacc_done` while in RUN or DRAIN.
  - Saturates at all-ones.
  - Holds its value in IDLE until the next accept.
- `start` while `ready`=0 is ignored; there is no queuing.
- `rem` is a full BCNT-bit down-counter and does not wrap; max job = 2^BCNT−1 steps.

## Timing
- Reset values:
  - State IDLE, `rem`=0, `dcnt`=0, `acc_count`=0.
  - `ready`=1, `busy`=0, `agu_clr`=0, `agu_en`=0, `done`=0, `aborted`=0.
- Reset asserted mid-job: immediate return to IDLE. No `done`/`aborted` pulse and no `agu_clr`; downstream relies on the shared `rst`.
- Accept at cycle 0, no stalls:
  - `agu_clr` at cycle 1.
  - `agu_en` cycles 2..N+1.
  - DRAIN cycles N+2..N+LATENCY+1.
  - `done` at N+LATENCY+2.
  - `ready` at N+LATENCY+3.
- Each stalled RUN cycle delays all later events by one cycle.
- Zero-length job: accept at cycle 0, `done` at cycle 1, no `agu_clr` or `agu_en`.
- `abort` and the final step in the same cycle: abort wins, `agu_en`=0, `rem` is unchanged, next state ABORT.
- Earliest back-to-back accept is the cycle after DONE.

## Test plan
- Basic job: `LATENCY`=2, `cfg_len`=4, start at cycle 0, no stall -> `agu_clr`@1, `agu_en`@2–5, `done`@8, `ready`@9, exactly 4 `agu_en` cycles.
- Stall: `cfg_len`=4, `stall` high at cycles 3 and 4 -> `agu_en` high at 2, 5, 6, 7 (4 total), `done`@10.
- Zero length and `LATENCY`=0:
  - `cfg_len`=0 -> `done`@1, no `agu_clr`.
  - With `LATENCY`=0, `cfg_len`=3 -> `done`@5.
- Abort:
  - `abort` at cycle 3 of a `cfg_len`=10 job -> `agu_en`=0@3, `agu_clr`+`aborted`@4, `ready`@5, no `done`.
  - Abort coinciding with the final step -> same sequence.
- Accumulator count:
  - 5 `shacc_done` pulses during RUN/DRAIN plus 2 in IDLE -> `acc_count`=5, held after `done`, cleared on next accept.
  - With `BACC`=2, 6 pulses -> saturates at 3.
- Handshake/reset:
  - `start` held high through a job -> second job accepted only in the cycle after `done`.
  - `rst` pulsed mid-RUN -> all outputs return to reset values asynchronously and no pulses follow.
